// File: rtl/uart_tx_frame_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_frame_arbiter_if                                                 |
// | Requester side and UART TX byte stream of the frame arbiter.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface uart_tx_frame_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 tx_ready;

    // master: the arbiter itself; slave: requesters plus the TX byte engine
    modport master (
        input  req,
        input  req_data,
        input  tx_ready,
        output ack,
        output tx_valid,
        output tx_data
    );

    modport slave (
        output req,
        output req_data,
        output tx_ready,
        input  ack,
        input  tx_valid,
        input  tx_data
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_frame_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_frame_arbiter                                                    |
// | Round-robin sharing of one UART TX byte engine; each grant sends a       |
// | 4-byte frame: header, requester ID, payload, XOR checksum.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_tx_frame_arbiter #(
    parameter int         NUM_REQ = 4,
    parameter logic [7:0] HEADER  = 8'hA5
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    uart_tx_frame_arbiter_if.master bus,
    output logic                    busy,
    output logic [15:0]             frame_cnt
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_ID   = 3'd2,
        S_PAY  = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t             state_q,     state_d;
    logic [IDW-1:0]     ptr_q,       ptr_d;
    logic [IDW-1:0]     gid_q,       gid_d;
    logic [7:0]         pay_q,       pay_d;
    logic               tx_valid_q,  tx_valid_d;
    logic [7:0]         tx_data_q,   tx_data_d;
    logic [NUM_REQ-1:0] ack_q,       ack_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [7:0]         grant_pay;
    logic [7:0]         id_byte;
    int                 cand;
    logic [IDW-1:0]     cand_idx;

    assign id_byte = 8'(gid_q);

    // First requester at or after the pointer, wrapping past NUM_REQ-1
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDW'(cand);
            if (!grant_found && bus.req[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        grant_pay = 8'h00;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_idx == IDW'(j)) begin
                grant_pay = bus.req_data[8*j +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        pay_d       = pay_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        ack_d       = '0;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    gid_d      = grant_idx;
                    pay_d      = grant_pay;
                    state_d    = S_HDR;
                    tx_valid_d = 1'b1;
                    tx_data_d  = HEADER;
                end
            end
            S_HDR: begin
                if (bus.tx_ready) begin
                    state_d   = S_ID;
                    tx_data_d = id_byte;
                end
            end
            S_ID: begin
                if (bus.tx_ready) begin
                    state_d   = S_PAY;
                    tx_data_d = pay_q;
                end
            end
            S_PAY: begin
                if (bus.tx_ready) begin
                    state_d   = S_CSUM;
                    tx_data_d = HEADER ^ id_byte ^ pay_q;
                end
            end
            S_CSUM: begin
                // Completion side effects land together so they are visible in DONE
                if (bus.tx_ready) begin
                    state_d     = S_DONE;
                    tx_valid_d  = 1'b0;
                    ack_d       = NUM_REQ'(1) << gid_q;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    ptr_d       = (gid_q == IDW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gid_q       <= '0;
            pay_q       <= 8'h00;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            ack_q       <= '0;
            frame_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gid_q       <= gid_d;
            pay_q       <= pay_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            ack_q       <= ack_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.ack      = ack_q;
    assign busy         = (state_q != S_IDLE);
    assign frame_cnt    = frame_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_frame_arbiter                                                 |
// | Directed vectors, corner sequences and randomized traffic for the        |
// | UART TX frame arbiter.                                                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_uart_tx_frame_arbiter;
    localparam int NR = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        busy;
    logic [15:0] frame_cnt;

    uart_tx_frame_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_frame_arbiter #(.NUM_REQ(NR), .HEADER(8'hA5)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Observed traffic and reference-model expectations
    logic [7:0]    byte_q[$];
    logic [NR-1:0] ack_seen[$];
    logic [7:0]    exp_q[$];
    logic [NR-1:0] exp_ack_q[$];
    int            model_ptr  = 0;
    logic          prev_valid = 1'b0;
    logic          stall_pend = 1'b0;
    logic [7:0]    stall_data = 8'h00;
    logic [NR-1:0] snap_req   = '0;
    logic [8*NR-1:0] snap_data = '0;
    int            pick;
    logic [7:0]    m_id, m_pay;

    function automatic int rr_pick(input logic [NR-1:0] r, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (r[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            exp_q.delete();
            exp_ack_q.delete();
            model_ptr  = 0;
            stall_pend = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (stall_pend) begin
                check("hold_valid", 32'(bus.tx_valid), 32'd1);
                check("hold_data", 32'(bus.tx_data), 32'(stall_data));
            end
            if (bus.tx_valid && !prev_valid) begin
                pick = rr_pick(snap_req, model_ptr);
                check("grant_had_request", 32'(snap_req != '0), 32'd1);
                if (pick >= 0) begin
                    m_id  = 8'(pick);
                    m_pay = snap_data[8*pick +: 8];
                    exp_q.push_back(8'hA5);
                    exp_q.push_back(m_id);
                    exp_q.push_back(m_pay);
                    exp_q.push_back(8'hA5 ^ m_id ^ m_pay);
                    exp_ack_q.push_back(NR'(1) << pick);
                    model_ptr = (pick + 1) % NR;
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                byte_q.push_back(bus.tx_data);
                if (exp_q.size() > 0) begin
                    check("model_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                end else begin
                    total++;
                    bad++;
                    $display("FAIL model_byte unexpected actual=%0h required=none", bus.tx_data);
                end
            end
            if (bus.ack != '0) begin
                ack_seen.push_back(bus.ack);
                if (exp_ack_q.size() > 0) begin
                    check("model_ack", 32'(bus.ack), 32'(exp_ack_q.pop_front()));
                end else begin
                    total++;
                    bad++;
                    $display("FAIL model_ack unexpected actual=%0h required=none", bus.ack);
                end
            end
            prev_valid = bus.tx_valid;
            stall_pend = bus.tx_valid && !bus.tx_ready;
            stall_data = bus.tx_data;
        end
        snap_req  = bus.req;
        snap_data = bus.req_data;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset(input logic [NR-1:0] r, input logic [31:0] d);
        sys_rst_n    = 1'b0;
        bus.req      = r;
        bus.req_data = d;
        bus.tx_ready = 1'b1;
        tick();
        tick();
        sys_rst_n = 1'b1;
        byte_q.delete();
        ack_seen.delete();
    endtask

    task automatic wait_ack(output logic [NR-1:0] a, input string nm);
        logic got;
        got = 1'b0;
        a   = '0;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            if (bus.ack != '0) begin
                a   = bus.ack;
                got = 1'b1;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s ack timeout actual=none required=ack", nm);
        end
    endtask

    function automatic logic [31:0] first_word();
        logic [31:0] w;
        w = 32'h0;
        for (int k = 0; k < 4 && k < byte_q.size(); k++) w = {w[23:0], byte_q[k]};
        return w;
    endfunction

    typedef struct packed {
        logic [NR-1:0] req;
        logic [31:0]   data;
        logic [31:0]   bytes;
        logic [NR-1:0] ack;
    } vec_t;

    vec_t          vecs[7];
    logic [NR-1:0] a;
    logic [NR-1:0] pend;
    int            nacks;
    int            ack_cyc[$];
    int            cyc;

    initial begin
        // Pointer evolves 0 -> 1 -> 3 -> 0 -> 2 -> 1 -> 2 -> 0 through the table
        vecs[0] = '{4'b0001, 32'h0000_003C, 32'hA500_3C99, 4'b0001};
        vecs[1] = '{4'b0100, 32'h0012_0000, 32'hA502_12B5, 4'b0100};
        vecs[2] = '{4'b1001, 32'h5A00_0077, 32'hA503_5AFC, 4'b1000};
        vecs[3] = '{4'b0110, 32'h0099_C300, 32'hA501_C367, 4'b0010};
        vecs[4] = '{4'b0011, 32'h0000_EE00, 32'hA500_00A5, 4'b0001};
        vecs[5] = '{4'b1111, 32'h1122_FF33, 32'hA501_FF5B, 4'b0010};
        vecs[6] = '{4'b1000, 32'h8000_0000, 32'hA503_8026, 4'b1000};

        do_reset('0, 32'h0);
        @(negedge sys_clk);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h00);
        check("rst_ack", 32'(bus.ack), 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        tick();

        for (int i = 0; i < 7; i++) begin
            byte_q.delete();
            ack_seen.delete();
            bus.req      = vecs[i].req;
            bus.req_data = vecs[i].data;
            @(negedge sys_clk);
            check("vec_idle_valid", 32'(bus.tx_valid), 32'd0);
            tick();
            @(negedge sys_clk);
            check("vec_lat_valid", 32'(bus.tx_valid), 32'd1);
            check("vec_lat_hdr", 32'(bus.tx_data), 32'hA5);
            check("vec_busy", 32'(busy), 32'd1);
            wait_ack(a, "vec");
            bus.req = '0;
            tick();
            tick();
            @(negedge sys_clk);
            check("vec_nbytes", 32'(byte_q.size()), 32'd4);
            check("vec_bytes", first_word(), vecs[i].bytes);
            check("vec_ack", 32'(a), 32'(vecs[i].ack));
            check("vec_ack_pulses", 32'(ack_seen.size()), 32'd1);
            check("vec_frame_cnt", 32'(frame_cnt), 32'(i + 1));
            check("vec_idle_busy", 32'(busy), 32'd0);
            tick();
        end

        // Continuously held requests alternate, one frame every 6 cycles
        do_reset(4'b0011, 32'h0000_113C);
        tick();
        @(negedge sys_clk);
        check("alt_first_hdr", 32'(bus.tx_data), 32'hA5);
        ack_cyc.delete();
        cyc = 0;
        while (ack_cyc.size() < 4 && cyc < 60) begin
            tick();
            cyc++;
            if (bus.ack != '0) ack_cyc.push_back(cyc);
        end
        bus.req = '0;
        tick();
        tick();
        tick();
        check("alt_nacks", 32'(ack_seen.size()), 32'd4);
        check("alt_nbytes", 32'(byte_q.size()), 32'd16);
        if (ack_seen.size() == 4 && byte_q.size() >= 16 && ack_cyc.size() == 4) begin
            check("alt_ack_seq", {ack_seen[0], ack_seen[1], ack_seen[2], ack_seen[3]}, 16'h1212);
            check("alt_id_seq", {byte_q[1], byte_q[5], byte_q[9], byte_q[13]}, 32'h0001_0001);
            check("alt_pay_seq", {byte_q[2], byte_q[6]}, 32'h3C11);
            check("alt_spacing", 32'(ack_cyc[3] - ack_cyc[0]), 32'd18);
        end

        // Three stall cycles while the payload byte is presented
        do_reset('0, 32'h0);
        bus.req      = 4'b0001;
        bus.req_data = 32'h0000_003C;
        tick();
        tick();
        tick();
        bus.tx_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            check("stall_data", 32'(bus.tx_data), 32'h3C);
            check("stall_valid", 32'(bus.tx_valid), 32'd1);
            tick();
        end
        bus.tx_ready = 1'b1;
        wait_ack(a, "stall");
        bus.req = '0;
        tick();
        tick();
        check("stall_nbytes", 32'(byte_q.size()), 32'd4);
        check("stall_bytes", first_word(), 32'hA500_3C99);

        // Payload and ID are frozen at grant even if the requester changes/drops
        do_reset('0, 32'h0);
        bus.req      = 4'b0001;
        bus.req_data = 32'h0000_003C;
        tick();
        bus.req      = '0;
        bus.req_data = 32'h0000_00FF;
        wait_ack(a, "latch");
        tick();
        tick();
        check("latch_ack", 32'(a), 32'h1);
        check("latch_bytes", first_word(), 32'hA500_3C99);

        // Reset during the ID byte aborts the frame
        do_reset('0, 32'h0);
        bus.req      = 4'b0001;
        bus.req_data = 32'h0000_003C;
        tick();
        tick();
        sys_rst_n = 1'b0;
        bus.req   = '0;
        tick();
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("abort_valid", 32'(bus.tx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(bus.ack), 32'h0);
        check("abort_frame_cnt", 32'(frame_cnt), 32'h0);
        for (int k = 0; k < 8; k++) tick();
        check("abort_no_ack", 32'(ack_seen.size()), 32'd0);
        check("abort_nbytes", 32'(byte_q.size()), 32'd1);

        // Counter wrap from FFFF
        @(negedge sys_clk);
        force dut.frame_cnt_q = 16'hFFFF;
        tick();
        release dut.frame_cnt_q;
        @(negedge sys_clk);
        check("wrap_preload", 32'(frame_cnt), 32'hFFFF);
        tick();
        bus.req      = 4'b0010;
        bus.req_data = 32'h0000_5500;
        wait_ack(a, "wrap");
        bus.req = '0;
        tick();
        @(negedge sys_clk);
        check("wrap_frame_cnt", 32'(frame_cnt), 32'h0000);
        tick();

        // Randomized traffic against the reference model
        do_reset('0, 32'h0);
        pend  = '0;
        nacks = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (bus.ack != '0) begin
                pend = pend & ~bus.ack;
                nacks++;
            end
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 7) == 0) pend[i] = 1'b1;
            end
            bus.req = pend;
            if ($urandom_range(0, 3) == 0) bus.req_data = $urandom();
            bus.tx_ready = ($urandom_range(0, 3) != 0);
        end
        bus.tx_ready = 1'b1;
        cyc = 0;
        while ((pend != '0 || busy) && cyc < 200) begin
            tick();
            cyc++;
            if (bus.ack != '0) begin
                pend = pend & ~bus.ack;
                nacks++;
            end
            bus.req = pend;
        end
        tick();
        tick();
        check("rand_drained", 32'(pend), 32'h0);
        check("rand_exp_bytes_left", 32'(exp_q.size()), 32'd0);
        check("rand_exp_acks_left", 32'(exp_ack_q.size()), 32'd0);
        check("rand_frame_cnt", 32'(frame_cnt), 32'(nacks[15:0]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
